// File: rtl/pokey_clk_pkg.sv
// pokey_clk_pkg -- shared constants and helpers for the POKEY machine-clock
// generator and the cells that integrate it.
//   SYS_HZ     : system clock frequency driving the phase accumulator
//   ACC_W_DEF  : default phase-accumulator width
//   INC_DEF    : default increment (~1.78977 MHz from 50 MHz)
//   DIV64/DIV15: p-strobes per 64 kHz / 15 kHz base-clock enable
//   calc_inc() : rounded increment for a target frequency at ACC_W_DEF bits
package pokey_clk_pkg;

  localparam int unsigned SYS_HZ    = 50_000_000;
  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned INC_DEF   = 600548;
  localparam int unsigned DIV64     = 28;
  localparam int unsigned DIV15     = 114;

  // Round-to-nearest increment: target_hz * 2^ACC_W_DEF / SYS_HZ.
  function automatic int unsigned calc_inc(input longint unsigned target_hz);
    longint unsigned scaled;
    scaled = (target_hz << ACC_W_DEF) + longint'(SYS_HZ / 2);
    return 32'(scaled / longint'(SYS_HZ));
  endfunction

endpackage

// File: rtl/pokey_clk_gen_pulse_div.sv
// pulse_div -- counts tick pulses modulo N and emits a one-clk strobe on
// every N-th tick. The strobe is registered, so when tick is the
// combinational "next p" it lands in the same cycle as the registered p.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   run    : 0 freezes the count and forces strobe low
//   tick   : one-clk event to count
//   strobe : one-clk pulse, registered, on the N-th tick
module pulse_div
  import pokey_clk_pkg::*;
#(
  parameter int unsigned N = DIV64
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic tick,
  output logic strobe
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;
  logic          hit;

  assign hit = run & tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= hit & (cnt == LAST);
      if (hit) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pokey_clk_gen.sv
// pokey_clk_gen -- POKEY slow machine clock from the 50 MHz system clock via
// a fractional phase accumulator, with registered edge strobes and the
// 64 kHz / 15 kHz base-clock enables.
//   clk     : system clock, all logic on posedge
//   reset   : asynchronous active-high reset
//   run     : 1 = accumulate and strobe, 0 = freeze state, strobes low
//   phi     : slow clock level (registered accumulator MSB)
//   p / n   : one-clk strobes on phi rising / falling edge
//   en_a    : one-clk strobe on every DIV_A-th p
//   en_b    : one-clk strobe on every DIV_B-th p
// Optional build macro PHI_EXT_EN adds:
//   phi_ext : asynchronous external slow clock
//   ext_sel : 1 = derive phi/p/n from synchronized phi_ext
module pokey_clk_gen
  import pokey_clk_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned INC   = INC_DEF,
  parameter int unsigned DIV_A = DIV64,
  parameter int unsigned DIV_B = DIV15
) (
  input  logic clk,
  input  logic reset,
`ifdef PHI_EXT_EN
  input  logic phi_ext,
  input  logic ext_sel,
`endif
  input  logic run,
  output logic phi,
  output logic p,
  output logic n,
  output logic en_a,
  output logic en_b
);

  // An increment of half the range or more would let phi skip a level.
  if (INC == 0 || longint'(INC) >= (longint'(1) << (ACC_W - 1))) begin : g_bad_inc
    $error("pokey_clk_gen: INC must satisfy 0 < INC < 2^(ACC_W-1)");
  end

  localparam logic [ACC_W-1:0] INC_V = ACC_W'(INC);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             src_level;
  logic             p_next;
  logic             n_next;

  // Wrap-around modulo 2^ACC_W is the fractional divider itself.
  assign acc_next = acc + INC_V;

`ifdef PHI_EXT_EN
  // First synchronizer flop; phi is the second, giving 2 clk edge-to-strobe.
  logic ext_meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ext_meta <= 1'b0;
    else       ext_meta <= phi_ext;
  end

  assign src_level = ext_sel ? ext_meta : acc_next[ACC_W-1];
`else
  assign src_level = acc_next[ACC_W-1];
`endif

  // Edge detect against the current registered level, so strobes come out
  // aligned with the first cycle of the new phi level.
  assign p_next = run &  src_level & ~phi;
  assign n_next = run & ~src_level &  phi;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      phi <= 1'b0;
      p   <= 1'b0;
      n   <= 1'b0;
    end else begin
      p <= p_next;
      n <= n_next;
      if (run) begin
        acc <= acc_next;
        phi <= src_level;
      end
    end
  end

  pulse_div #(.N(DIV_A)) u_div_a (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .tick   (p_next),
    .strobe (en_a)
  );

  pulse_div #(.N(DIV_B)) u_div_b (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .tick   (p_next),
    .strobe (en_b)
  );

endmodule

// File: tb/tb_pokey_clk_gen.sv
// tb_pokey_clk_gen -- scoreboard bench. The stimulus process drives run and
// pushes the expected outputs for the coming clk edge; an independent monitor
// pops and compares one entry per edge. The reference derives phi from the
// total count of run=1 cycles since reset (phase = k*INC mod 2^ACC_W) and the
// enables from the running count of p strobes.
module tb_pokey_clk_gen;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned INC   = 45;
  localparam int unsigned DIV_A = 3;
  localparam int unsigned DIV_B = 5;
  localparam longint      MODV  = longint'(1) << ACC_W;
  localparam longint      HALF  = MODV / 2;

  typedef struct packed {
    logic phi;
    logic p;
    logic n;
    logic en_a;
    logic en_b;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic phi, p, n, en_a, en_b;

  obs_t   exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  longint k;
  logic   m_phi;
  int     pcount;

  always #10 clk = ~clk;

  pokey_clk_gen #(
    .ACC_W (ACC_W),
    .INC   (INC),
    .DIV_A (DIV_A),
    .DIV_B (DIV_B)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .phi   (phi),
    .p     (p),
    .n     (n),
    .en_a  (en_a),
    .en_b  (en_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic phase_high(input longint kk);
    return ((kk * longint'(INC)) % MODV) >= HALF;
  endfunction

  task automatic model_reset();
    k      = 0;
    m_phi  = 1'b0;
    pcount = 0;
  endtask

  // Expected outputs after the next clk edge, given run for that edge.
  task automatic model_step(input logic r);
    obs_t e;
    e = '0;
    if (r) begin
      k++;
      e.phi = phase_high(k);
      e.p   = e.phi & ~m_phi;
      e.n   = ~e.phi & m_phi;
      if (e.p) begin
        pcount++;
        e.en_a = (pcount % DIV_A) == 0;
        e.en_b = (pcount % DIV_B) == 0;
      end
    end else begin
      e.phi = m_phi;
    end
    m_phi = e.phi;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r);
    @(negedge clk);
    run = r;
    model_step(r);
  endtask

  // Monitor: one output beat per clk edge while expectations are queued.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {3'b000, phi, p, n, en_a, en_b}, {3'b000, e});
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    run   = 1'b0;
    model_reset();
    #25;
    check("reset_state", {3'b000, phi, p, n, en_a, en_b}, 8'h00);

    @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    model_step(1'b1);

    // Randomized run gating.
    repeat (250) drive($urandom_range(0, 99) < 85);

    // Hold run low for 7 clk while phi is high.
    guard = 0;
    while (!m_phi && guard < 20) begin
      drive(1'b1);
      guard++;
    end
    repeat (7) drive(1'b0);
    repeat (20) drive(1'b1);

    // Asynchronous reset in the middle of a high phase.
    guard = 0;
    while (!m_phi && guard < 20) begin
      drive(1'b1);
      guard++;
    end
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", {3'b000, phi, p, n, en_a, en_b}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    run = 1'b1;
    model_step(1'b1);

    repeat (400) drive($urandom_range(0, 99) < 90);
    repeat (3) drive(1'b0);

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pokey_clk_gen.md
Name: pokey_clk_gen

Overview:
Generates the slow POKEY machine-clock level and its one-cycle edge strobes from the 50 MHz system clock. It uses a fractional phase accumulator, so no external slow clock is needed.
- Outputs feed the p/n strobe inputs of shift cells such as cell25.
- Also derives the 64 kHz (÷28) and 15 kHz (÷114) base-clock enables used by the audio and serial dividers.
- Sits directly upstream of every slow-clocked cell.

Parameters:
ACC_W, 24, phase-accumulator width in bits.
INC, 600548, accumulator increment per clk; f_phi = 50 MHz * INC / 2^ACC_W (default ≈ 1.78977 MHz). Elaboration error if INC == 0 or INC >= 2^(ACC_W-1).
DIV_A, 28, p-strobes per en_a pulse (64 kHz base).
DIV_B, 114, p-strobes per en_b pulse (15 kHz base).

Ports:
clk  input  1  50 MHz system clock; all logic on posedge.
reset  input  1  asynchronous, active-high reset.
run  input  1  1 = accumulate and strobe; 0 = freeze all state.
phi  output  1  slow clock level, registered accumulator MSB.
p  output  1  one-clk strobe on phi rising edge.
n  output  1  one-clk strobe on phi falling edge.
en_a  output  1  one-clk strobe, coincident with every DIV_A-th p.
en_b  output  1  one-clk strobe, coincident with every DIV_B-th p.

Behaviour:
- Reset (asynchronous): acc=0, phi=0, p=0, n=0, cnt_a=0, cnt_b=0, en_a=0, en_b=0. Outputs are valid from the first clk edge after deassertion.
- Accumulator, each clk with run=1: acc <= acc + INC, modulo 2^ACC_W (wrap-around is intended).
- phi <= next acc MSB, so phi is registered with one clk of latency from the accumulator.
- Edge strobes:
  - p = 1 for exactly the one clk in which phi goes 0→1.
  - n = 1 for exactly the one clk in which phi goes 1→0.
  - Both are registered alongside phi, so each strobe is aligned with the first cycle of the new phi level.
- Because INC < 2^(ACC_W-1), phi holds each level for ≥1 clk. p and n are never asserted together, and two p's are never adjacent.
- Divider counters:
  - cnt_a counts 0..DIV_A-1 on p strobes only.
  - When p=1 and cnt_a==DIV_A-1: en_a=1 in that same cycle and cnt_a wraps to 0.
  - cnt_b behaves identically with DIV_B.
  - en_a and en_b may coincide (every 28*114/gcd p's); both assert, with no priority.
- run=0: acc, phi, cnt_a and cnt_b hold; p, n, en_a and en_b are forced 0 in the same cycle.
  - On run reasserting, the accumulation continues from the held value and no spurious edge is emitted.
- Reset mid-period discards the partial phase. The first p after reset occurs after ceil(2^(ACC_W-1)/INC) clks of run=1.
- Average strobe rate equals f_phi exactly. Individual period jitter is ≤1 clk (20 ns).

Optional Feature:
PHI_EXT_EN
- Defined:
  - Adds inputs phi_ext (asynchronous slow clock) and ext_sel (1 bit).
  - With ext_sel=1, phi_ext passes through a 2-flop synchronizer, and phi/p/n are derived from the synchronized level. Latency is 2 clk from a phi_ext edge to the p/n strobe.
  - The accumulator keeps running but is ignored.
  - ext_sel changes take effect at a clk edge. A level mismatch at switchover produces at most one p or n, never both.
  - run=0 still freezes outputs and counters.
- Undefined: no ports are added and the accumulator is the sole source.

Decomposition:
- Shared package pokey_clk_pkg holds:
  - constants SYS_HZ=50_000_000, ACC_W_DEF=24, INC_DEF=600548, DIV64=28, DIV15=114;
  - the function calc_inc(target_hz) used by integrators.
- One sub-module, pulse_div (parameter N, inputs clk/reset/run/tick, output strobe), instantiated twice for en_a and en_b.

Test Plan:
1. ACC_W=8, INC=64, run=1 after reset: phi period 4 clk (2 high/2 low); p at clk 2,6,10…; n at clk 4,8,12…; never simultaneous.
2. ACC_W=8, INC=64, DIV_A=3, DIV_B=5: en_a on every 3rd p, en_b on every 5th p; both assert together on the 15th p; counters wrap to 0.
3. Defaults, 1 ms run: p count = 1789 or 1790; max-min p spacing ≤1 clk; en_a count 63–64; en_b count 15–16.
4. run dropped for 7 clk while phi=1: p, n, en_a, en_b stay 0 throughout; next n after run=1 arrives at the same accumulated phase (total run=1 clk count unchanged).
5. reset pulsed asynchronously mid-high-phase: phi, p, n, en_* go 0 immediately without waiting for clk; cnt_a/cnt_b restart so the first en_a lands on the 28th p after release.
6. (PHI_EXT_EN) ext_sel=1, phi_ext square wave at 661.38 ns period: p exactly 2 clk after each phi_ext rise, n 2 clk after each fall, each 1 clk wide.
